io_input_ctrl: RTL and testbench
================================

// Module: io_input_ctrl
// PURPOSE
//   Memory-mapped input peripheral that feeds the data-memory read path with clean KEY/SW values.
//   - Synchronises the raw KEY[3:0] and SW[9:0] pins and debounces each bit.
//   - Latches sticky key-press events.
//   - Returns a read word when the processor addresses ADDR_KEY, ADDR_SW or ADDR_KCTRL.
//   - Sits between the board pins and the data-memory read mux, replacing direct pin reads.
// PARAMETERS
//   DBITS           32            data/address width
//   DEBOUNCE_CYCLES 500000        consecutive stable cycles needed to accept a change (>=1)
//   CNT_BITS        19            debounce counter width; 2**CNT_BITS > DEBOUNCE_CYCLES
//   ADDR_KEY        32'hF0000010  debounced key levels, read-only
//   ADDR_SW         32'hF0000014  debounced switch levels, read-only
//   ADDR_KCTRL      32'hF0000110  sticky key-press flags, read / write-1-to-clear
// PORTS
//   clk     in   1      system clock (PLL c0)
//   reset   in   1      asynchronous, active-low reset
//   KEY     in   4      raw push buttons, active-low at the pin
//   SW      in   10     raw slide switches
//   addr    in   DBITS  processor data address (ALU result)
//   wrEn    in   1      data-memory write enable
//   wdata   in   DBITS  store data (rs2 value)
//   hit     out  1      addr matches one of the three addresses
//   rdata   out  DBITS  read word; 0 when hit=0
// BEHAVIOUR
//   Reset (reset=0, async assert, released on next clk edge):
//     - synchronisers: key = not pressed, sw = 0
//     - keyStable, swStable, all counters and keyFlag = 0
//     - rdata/hit follow the comb rules below from these values
//   Inversion: key bits are inverted before synchronisation, so 1 = pressed everywhere inside.
//   Sync: two flops per bit; syncd lags the pin by 2 clk edges.
//   Debounce, per bit, independent (14 instances):
//     - syncd == stable: cnt <= 0
//     - syncd != stable and cnt == DEBOUNCE_CYCLES-1: stable <= syncd, cnt <= 0
//     - otherwise: cnt <= cnt+1
//     - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches stable.
//     - cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around.
//   Latency: a clean pin step appears on stable after 2+DEBOUNCE_CYCLES clk edges.
//   Press event: keyStable[i] 0->1 sets keyFlag[i]; release (1->0) does not touch it.
//   Clear: wrEn & addr==ADDR_KCTRL & wdata[i]==1 clears keyFlag[i] at the clk edge.
//     - If set and clear land on the same edge, set wins (the flag stays 1).
//     - Writes to ADDR_KEY / ADDR_SW are ignored.
//   Read data (combinational, no read strobe, reads have no side effects):
//     - ADDR_KEY   -> {28'b0, keyStable}
//     - ADDR_SW    -> {22'b0, swStable}
//     - ADDR_KCTRL -> {28'b0, keyFlag}
//     - hit = 1 for these three addresses only; any other address -> hit = 0, rdata = 0.
//   Mid-operation reset: counters and flags drop to 0 at once; a change already in progress must be re-qualified in full.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//   1. Reset, no activity -> read ADDR_KEY=0, ADDR_SW=0, ADDR_KCTRL=0; addr=0x100 gives hit=0, rdata=0.
//   2. SW=10'h2A5 held -> ADDR_SW reads 0x2A5 exactly 6 edges later, still 0 after 5 edges.
//   3. KEY[2] low for 3 cycles then high -> ADDR_KEY stays 0 and ADDR_KCTRL stays 0 (glitch rejected).
//   4. KEY[0] held low 10 cycles, released -> ADDR_KEY=0x1 then 0x0 after release qualifies; ADDR_KCTRL stays 0x1.
//   5. With flags 0xF: write 0x5 to ADDR_KCTRL -> reads 0xA; write 0xF to ADDR_SW -> ADDR_SW unchanged.
//   6. Press edge on KEY[1] on the same edge as a clear write of 0x2 -> ADDR_KCTRL bit1 reads 1.
//   7. Assert reset while KEY[3] is 2 cycles into debounce -> after release, 6 more edges are needed before ADDR_KEY=0x8.

Source files
------------

// File: rtl/io_input_ctrl.sv
// io_input_ctrl: synchronised, debounced KEY/SW pins with sticky key-press flags on the data-memory read path
module io_input_ctrl #(
    parameter int DBITS = 32,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_BITS = 19,
    parameter logic [DBITS-1:0] ADDR_KEY = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SW = 32'hF0000014,
    parameter logic [DBITS-1:0] ADDR_KCTRL = 32'hF0000110
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    input  logic [DBITS-1:0] addr,
    input  logic             wrEn,
    input  logic [DBITS-1:0] wdata,
    output logic             hit,
    output logic [DBITS-1:0] rdata
);
    localparam int NB = 14;
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);
    logic [NB-1:0] raw, sync1, syncd, stable, stableNext;
    logic [3:0] keyStable, keyFlag, keyClr, keyRise;
    logic [9:0] swStable;
    logic isKey, isSw, isKctrl;
    logic unusedWdata;
    // Keys are active-low at the pin; inside, 1 means pressed. Bits [3:0] keys, [13:4] switches.
    assign raw = {SW, ~KEY};
    assign keyStable = stable[3:0];
    assign swStable = stable[13:4];
    assign isKey = addr == ADDR_KEY;
    assign isSw = addr == ADDR_SW;
    assign isKctrl = addr == ADDR_KCTRL;
    assign keyClr = (wrEn && isKctrl) ? wdata[3:0] : 4'h0;
    assign keyRise = stableNext[3:0] & ~keyStable;
    assign unusedWdata = ^wdata[DBITS-1:4];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            syncd <= '0;
            stable <= '0;
            keyFlag <= '0;
        end else begin
            sync1 <= raw;
            syncd <= sync1;
            stable <= stableNext;
            keyFlag <= (keyFlag & ~keyClr) | keyRise;
        end
    end
    for (genvar i = 0; i < NB; i++) begin : g_db
        logic [CNT_BITS-1:0] cnt;
        logic done;
        assign done = syncd[i] != stable[i] && cnt == CNT_LAST;
        assign stableNext[i] = done ? syncd[i] : stable[i];
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) cnt <= '0;
            else cnt <= (syncd[i] == stable[i] || done) ? '0 : cnt + 1'b1;
        end
    end
    always_comb begin
        hit = isKey || isSw || isKctrl;
        rdata = isKey ? DBITS'(keyStable) :
                isSw ? DBITS'(swStable) :
                isKctrl ? DBITS'(keyFlag) : '0;
    end
endmodule

// File: tb/tb_io_input_ctrl.sv
// tb_io_input_ctrl: directed vectors plus randomized pin/write traffic against a history-based model
module tb_io_input_ctrl;
    localparam int D = 4;
    localparam logic [31:0] A_KEY = 32'hF0000010, A_SW = 32'hF0000014, A_KC = 32'hF0000110;
    logic clk = 0, reset = 1, wrEn = 0, hit;
    logic [3:0] KEY = 4'hF;
    logic [9:0] SW = '0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    int checks = 0, fails = 0;
    // Model: mh[0] is the newest pin sample; a bit flips once the samples two or more edges old have sat at the opposite level for D edges
    logic [13:0] mh [0:D];
    logic [13:0] mStable;
    logic [3:0] mFlag;

    typedef struct {
        logic [31:0] a;
        logic h;
        logic [31:0] d;
    } rv_t;
    rv_t tbl [6];

    io_input_ctrl #(.DBITS(32), .DEBOUNCE_CYCLES(D), .CNT_BITS(3),
        .ADDR_KEY(A_KEY), .ADDR_SW(A_SW), .ADDR_KCTRL(A_KC)) dut (
        .clk(clk), .reset(reset), .KEY(KEY), .SW(SW), .addr(addr),
        .wrEn(wrEn), .wdata(wdata), .hit(hit), .rdata(rdata));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int j = 0; j <= D; j++) mh[j] = '0;
        mStable = '0;
        mFlag = '0;
    endtask

    task automatic tick();
        logic [13:0] pin, flip;
        logic [3:0] clr;
        pin = {SW, ~KEY};
        clr = (wrEn && addr == A_KC) ? wdata[3:0] : 4'h0;
        flip = '1;
        for (int j = 1; j <= D; j++) flip &= mh[j] ^ mStable;
        @(posedge clk);
        mFlag = (mFlag & ~clr) | (flip[3:0] & ~mStable[3:0]);
        mStable ^= flip;
        for (int j = D; j > 0; j--) mh[j] = mh[j-1];
        mh[0] = pin;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    task automatic doReset();
        reset = 0;
        modelReset();
        @(negedge clk);
        reset = 1;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wdata = d;
        wrEn = 1;
        tick();
        wrEn = 0;
    endtask

    function automatic logic [31:0] mRead(input logic [31:0] a);
        return a == A_KEY ? {28'h0, mStable[3:0]} :
               a == A_SW ? {22'h0, mStable[13:4]} :
               a == A_KC ? {28'h0, mFlag} : 32'h0;
    endfunction

    initial begin
        tbl[0] = '{A_KEY, 1'b1, 32'h0};
        tbl[1] = '{A_SW, 1'b1, 32'h0};
        tbl[2] = '{A_KC, 1'b1, 32'h0};
        tbl[3] = '{32'h100, 1'b0, 32'h0};
        tbl[4] = '{32'hF0000011, 1'b0, 32'h0};
        tbl[5] = '{32'hF0000114, 1'b0, 32'h0};
        #1;
        doReset();
        ticks(3);
        for (int k = 0; k < 6; k++) begin
            addr = tbl[k].a;
            #1;
            check($sformatf("reset_hit[%0d]", k), {31'h0, hit}, {31'h0, tbl[k].h});
            check($sformatf("reset_rdata[%0d]", k), rdata, tbl[k].d);
        end
        SW = 10'h2A5;
        ticks(5);
        rd("sw_early", A_SW, 32'h0);
        tick();
        rd("sw_latency", A_SW, 32'h2A5);
        check("sw_hit", {31'h0, hit}, 32'h1);
        KEY = 4'b1011;
        ticks(3);
        KEY = 4'hF;
        ticks(10);
        rd("glitch_key", A_KEY, 32'h0);
        rd("glitch_flag", A_KC, 32'h0);
        KEY = 4'b1110;
        ticks(10);
        rd("press_key", A_KEY, 32'h1);
        rd("press_flag", A_KC, 32'h1);
        KEY = 4'hF;
        ticks(5);
        rd("release_early", A_KEY, 32'h1);
        tick();
        rd("release_key", A_KEY, 32'h0);
        rd("release_flag", A_KC, 32'h1);
        KEY = 4'h0;
        ticks(6);
        KEY = 4'hF;
        ticks(6);
        rd("all_flags", A_KC, 32'hF);
        wr(A_KC, 32'h5);
        rd("w1c_flags", A_KC, 32'hA);
        wr(A_SW, 32'hF);
        rd("sw_write_ignored", A_SW, 32'h2A5);
        wr(A_KEY, 32'hF);
        rd("key_write_ignored", A_KEY, 32'h0);
        wr(A_KC, 32'h2);
        rd("clear_bit1", A_KC, 32'h8);
        KEY = 4'b1101;
        ticks(5);
        rd("pre_rise_key", A_KEY, 32'h0);
        wr(A_KC, 32'h2);
        rd("set_wins_flag", A_KC, 32'hA);
        rd("set_wins_key", A_KEY, 32'h2);
        KEY = 4'hF;
        ticks(6);
        KEY = 4'b0111;
        ticks(4);
        doReset();
        rd("midreset_flag", A_KC, 32'h0);
        rd("midreset_sw", A_SW, 32'h0);
        ticks(5);
        rd("requal_early", A_KEY, 32'h0);
        tick();
        rd("requal_key", A_KEY, 32'h8);
        rd("requal_flag", A_KC, 32'h8);
        for (int it = 0; it < 600; it++) begin
            logic [31:0] a;
            if ($urandom_range(5) == 0) KEY = 4'($urandom);
            if ($urandom_range(7) == 0) SW = 10'($urandom);
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(3))
                    0: addr = A_KEY;
                    1: addr = A_SW;
                    2: addr = A_KC;
                    default: addr = $urandom;
                endcase
                addr = ($urandom_range(1) == 0) ? A_KC : addr;
                wdata = $urandom;
                wrEn = 1;
            end
            if ($urandom_range(199) == 0) doReset();
            tick();
            wrEn = 0;
            case ($urandom_range(3))
                0: a = A_KEY;
                1: a = A_SW;
                2: a = A_KC;
                default: a = 32'hF0000000 | 32'($urandom_range(511));
            endcase
            addr = a;
            #1;
            check("rand_hit", {31'h0, hit}, {31'h0, (a == A_KEY || a == A_SW || a == A_KC)});
            check("rand_rdata", rdata, mRead(a));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
